// File: rtl/dht_pkg.sv
// Shared types, frame layout and checksum helper for the DHT poll scheduler.
// Contents: state enum, 40-bit frame byte offsets, frame payload struct,
//           timer counter width and the four-byte 8-bit checksum function.
package dht_pkg;

   localparam int unsigned FRAME_W = 40;
   localparam int unsigned MS_W    = 16;

   localparam int unsigned HUM_INT_MSB  = 39;
   localparam int unsigned HUM_INT_LSB  = 32;
   localparam int unsigned HUM_DEC_MSB  = 31;
   localparam int unsigned HUM_DEC_LSB  = 24;
   localparam int unsigned TEMP_INT_MSB = 23;
   localparam int unsigned TEMP_INT_LSB = 16;
   localparam int unsigned TEMP_DEC_MSB = 15;
   localparam int unsigned TEMP_DEC_LSB = 8;
   localparam int unsigned CKSUM_MSB    = 7;
   localparam int unsigned CKSUM_LSB    = 0;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_CHECK     = 3'd3,
      ST_HOLDOFF   = 3'd4
   } dht_state_e;

   typedef struct packed {
      logic [7:0] hum_int;
      logic [7:0] hum_dec;
      logic [7:0] temp_int;
      logic [7:0] temp_dec;
      logic [7:0] cksum;
   } dht_frame_t;

   // Sensor checksum: plain 8-bit wrapping sum of the four data bytes.
   function automatic logic [7:0] dht_cksum(input logic [7:0] b4, input logic [7:0] b3,
                                            input logic [7:0] b2, input logic [7:0] b1);
      return b4 + b3 + b2 + b1;
   endfunction

endpackage

// File: rtl/dht_ms_timer.sv
// Millisecond timer: MS_DIV-cycle prescaler feeding a ms counter.
// Ports: clk, rst (async active-low), clr (restart both counters next edge),
//        limit (wait length in ms), reached (high in the last cycle of a
//        limit-ms wait, i.e. limit*MS_DIV cycles after the clearing edge).
module dht_ms_timer
   import dht_pkg::*;
#(
   parameter int unsigned MS_DIV = 100_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic [MS_W-1:0] limit,
   output logic            reached
);

   localparam int unsigned PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   logic [PRE_W-1:0] pre_q;
   logic [MS_W-1:0]  ms_q;
   logic             tick_c;

   assign tick_c = (pre_q == PRE_W'(MS_DIV - 1));

   // Firing on the last prescaler cycle of the final ms lets the caller leave
   // the state on the edge that completes exactly limit*MS_DIV cycles.
   assign reached = tick_c && (ms_q == (limit - MS_W'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else if (clr) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else if (tick_c) begin
         pre_q <= '0;
         ms_q  <= ms_q + MS_W'(1);
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

endmodule

// File: rtl/dht_poll_scheduler.sv
// DHT read sequencer: issues reads on enable/trig, supervises each with a
// timeout, validates the checksum, retries, and enforces hold-off intervals.
// Ports: clk, rst (async active-low), enable (continuous polling), trig
//        (one-shot request), rd_start/rd_done/rd_data (reader handshake),
//        hum_int/hum_dec/temp_int/temp_dec (last good frame), valid (update
//        strobe), err_cksum/err_timeout (last attempt status), busy (not
//        idle), fail_cnt (saturating count of reads failed after all retries).
module dht_poll_scheduler
   import dht_pkg::*;
#(
   parameter int unsigned MS_DIV     = 100_000,
   parameter int unsigned PERIOD_MS  = 2000,
   parameter int unsigned RETRY_MS   = 1000,
   parameter int unsigned TIMEOUT_MS = 10,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               trig,
   output logic               rd_start,
   input  logic               rd_done,
   input  logic [FRAME_W-1:0] rd_data,
   output logic [7:0]         hum_int,
   output logic [7:0]         hum_dec,
   output logic [7:0]         temp_int,
   output logic [7:0]         temp_dec,
   output logic               valid,
   output logic               err_cksum,
   output logic               err_timeout,
   output logic               busy,
   output logic [7:0]         fail_cnt
);

   localparam int unsigned ATT_W = 8;

   dht_state_e       state, next_state;
   dht_frame_t       frame_q, frame_d;
   logic [ATT_W-1:0] attempt_q, attempt_d;
   logic             retry_pend_q, retry_pend_d;
   logic [MS_W-1:0]  hold_q, hold_d, timer_limit_c;
   logic             timer_clr_c, timer_reached;
   logic             cksum_ok_c, load_bytes_c, fail_path_c;
   logic             rd_start_d, valid_d, err_cksum_d, err_timeout_d, busy_d;
   logic [7:0]       fail_cnt_d;

   assign cksum_ok_c = (dht_cksum(frame_q.hum_int, frame_q.hum_dec,
                                  frame_q.temp_int, frame_q.temp_dec) == frame_q.cksum);

   // Only WAIT_DONE and HOLDOFF consult the timer; any state change restarts it.
   assign timer_limit_c = (state == ST_WAIT_DONE) ? MS_W'(TIMEOUT_MS) : hold_q;
   assign timer_clr_c   = (next_state != state);

   dht_ms_timer #(
      .MS_DIV (MS_DIV)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr_c),
      .limit   (timer_limit_c),
      .reached (timer_reached)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // Next-state logic; rd_done beats a coincident timeout.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (enable || trig) next_state = ST_ISSUE;
         ST_ISSUE:     next_state = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (rd_done)            next_state = ST_CHECK;
            else if (timer_reached) next_state = ST_HOLDOFF;
         end
         ST_CHECK:     next_state = ST_HOLDOFF;
         ST_HOLDOFF:   if (timer_reached) next_state = retry_pend_q ? ST_ISSUE : ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      frame_d       = frame_q;
      attempt_d     = attempt_q;
      retry_pend_d  = retry_pend_q;
      hold_d        = hold_q;
      err_cksum_d   = err_cksum;
      err_timeout_d = err_timeout;
      fail_cnt_d    = fail_cnt;
      valid_d       = 1'b0;
      load_bytes_c  = 1'b0;
      fail_path_c   = 1'b0;
      rd_start_d    = (next_state == ST_ISSUE);
      busy_d        = (next_state != ST_IDLE);

      case (state)
         ST_WAIT_DONE: begin
            if (rd_done) begin
               frame_d.hum_int  = rd_data[HUM_INT_MSB:HUM_INT_LSB];
               frame_d.hum_dec  = rd_data[HUM_DEC_MSB:HUM_DEC_LSB];
               frame_d.temp_int = rd_data[TEMP_INT_MSB:TEMP_INT_LSB];
               frame_d.temp_dec = rd_data[TEMP_DEC_MSB:TEMP_DEC_LSB];
               frame_d.cksum    = rd_data[CKSUM_MSB:CKSUM_LSB];
            end else if (timer_reached) begin
               err_timeout_d = 1'b1;
               err_cksum_d   = 1'b0;
               fail_path_c   = 1'b1;
            end
         end
         ST_CHECK: begin
            if (cksum_ok_c) begin
               load_bytes_c  = 1'b1;
               valid_d       = 1'b1;
               err_cksum_d   = 1'b0;
               err_timeout_d = 1'b0;
               attempt_d     = '0;
               hold_d        = MS_W'(PERIOD_MS);
            end else begin
               err_cksum_d   = 1'b1;
               err_timeout_d = 1'b0;
               fail_path_c   = 1'b1;
            end
         end
         ST_HOLDOFF: if (timer_reached) retry_pend_d = 1'b0;
         default: ;
      endcase

      // Shared failure path: retry while attempts remain, else count the loss.
      if (fail_path_c) begin
         if (attempt_q < ATT_W'(MAX_RETRY - 1)) begin
            attempt_d    = attempt_q + ATT_W'(1);
            retry_pend_d = 1'b1;
            hold_d       = MS_W'(RETRY_MS);
         end else begin
            attempt_d    = '0;
            hold_d       = MS_W'(PERIOD_MS);
            fail_cnt_d   = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
         end
      end
   end

   // Registered outputs and datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q      <= '0;
         attempt_q    <= '0;
         retry_pend_q <= 1'b0;
         hold_q       <= '0;
         rd_start     <= 1'b0;
         valid        <= 1'b0;
         err_cksum    <= 1'b0;
         err_timeout  <= 1'b0;
         busy         <= 1'b0;
         fail_cnt     <= '0;
         hum_int      <= '0;
         hum_dec      <= '0;
         temp_int     <= '0;
         temp_dec     <= '0;
      end else begin
         frame_q      <= frame_d;
         attempt_q    <= attempt_d;
         retry_pend_q <= retry_pend_d;
         hold_q       <= hold_d;
         rd_start     <= rd_start_d;
         valid        <= valid_d;
         err_cksum    <= err_cksum_d;
         err_timeout  <= err_timeout_d;
         busy         <= busy_d;
         fail_cnt     <= fail_cnt_d;
         if (load_bytes_c) begin
            hum_int  <= frame_q.hum_int;
            hum_dec  <= frame_q.hum_dec;
            temp_int <= frame_q.temp_int;
            temp_dec <= frame_q.temp_dec;
         end
      end
   end

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Self-checking bench for dht_poll_scheduler with a small timing/scoreboard
// model derived from the read/retry/hold-off rules.
module tb_dht_poll_scheduler;

   localparam int MS_DIV      = 10;
   localparam int PERIOD_MS   = 5;
   localparam int RETRY_MS    = 2;
   localparam int TIMEOUT_MS  = 3;
   localparam int MAX_RETRY   = 2;
   localparam int PERIOD_CYC  = PERIOD_MS * MS_DIV;
   localparam int RETRY_CYC   = RETRY_MS * MS_DIV;
   localparam int TIMEOUT_CYC = TIMEOUT_MS * MS_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        trig = 1'b0;
   logic        rd_done = 1'b0;
   logic [39:0] rd_data = '0;
   logic        rd_start, valid, err_cksum, err_timeout, busy;
   logic [7:0]  hum_int, hum_dec, temp_int, temp_dec, fail_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model of the visible state.
   logic [7:0]  m_hi, m_hd, m_ti, m_td, m_fail;
   logic        m_eck, m_eto;
   // Per-attempt sensor behaviour: delay 0 means no reply at all.
   int          plan_dly[MAX_RETRY];
   logic [39:0] plan_frame[MAX_RETRY];

   dht_poll_scheduler #(
      .MS_DIV(MS_DIV), .PERIOD_MS(PERIOD_MS), .RETRY_MS(RETRY_MS),
      .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .trig(trig),
      .rd_start(rd_start), .rd_done(rd_done), .rd_data(rd_data),
      .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
      .valid(valid), .err_cksum(err_cksum), .err_timeout(err_timeout),
      .busy(busy), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit frame_ok(input logic [39:0] f);
      int s;
      s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
      return s == int'(f[7:0]);
   endfunction

   function automatic logic [39:0] make_frame(input bit good);
      logic [7:0] b4, b3, b2, b1, b0;
      int s;
      b4 = 8'($urandom); b3 = 8'($urandom); b2 = 8'($urandom); b1 = 8'($urandom);
      s  = (int'(b4) + int'(b3) + int'(b2) + int'(b1)) % 256;
      b0 = good ? 8'(s) : 8'((s + 1 + int'($urandom_range(0, 254))) % 256);
      return {b4, b3, b2, b1, b0};
   endfunction

   task automatic model_clear();
      m_hi = '0; m_hd = '0; m_ti = '0; m_td = '0; m_fail = '0;
      m_eck = 1'b0; m_eto = 1'b0;
   endtask

   // Negedges until rd_start is seen (-1 if budget runs out).
   task automatic wait_start(input int budget, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (rd_start !== 1'b1 && n < budget);
      if (rd_start !== 1'b1) n = -1;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < budget);
      if (busy !== 1'b0) n = -1;
   endtask

   task automatic fire_trig(input string tag);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      n_tests++;
      if (rd_start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s start_latency: rd_start=%b required 1", tag, rd_start);
      end
   endtask

   // Plays the sensor for one read (entered at the rd_start negedge) and checks
   // the outcome of every attempt plus the following retry/hold-off spacing.
   task automatic run_read(input string tag);
      int n;
      bit good, last, stop;
      stop = 1'b0;
      for (int a = 0; a < MAX_RETRY && !stop; a++) begin
         if (plan_dly[a] > 0) begin
            repeat (plan_dly[a]) @(negedge clk);
            rd_done = 1'b1; rd_data = plan_frame[a];
            @(negedge clk);
            rd_done = 1'b0; rd_data = 40'({$urandom, $urandom});
            @(negedge clk);
            good = frame_ok(plan_frame[a]);
         end else begin
            repeat (TIMEOUT_CYC + 1) @(negedge clk);
            good = 1'b0;
         end
         last = good || (a == MAX_RETRY - 1);
         if (good) {m_hi, m_hd, m_ti, m_td} = plan_frame[a][39:8];
         m_eck = !good && (plan_dly[a] > 0);
         m_eto = !good && (plan_dly[a] == 0);
         if (!good && last && m_fail != 8'hFF) m_fail = m_fail + 8'd1;

         n_tests++;
         if (valid !== good) begin
            n_fail++; $display("FAIL %s/a%0d valid: got %b required %b", tag, a, valid, good);
         end
         n_tests++;
         if ({hum_int, hum_dec, temp_int, temp_dec} !== {m_hi, m_hd, m_ti, m_td}) begin
            n_fail++;
            $display("FAIL %s/a%0d bytes: got %h required %h", tag, a,
                     {hum_int, hum_dec, temp_int, temp_dec}, {m_hi, m_hd, m_ti, m_td});
         end
         n_tests++;
         if ({err_cksum, err_timeout} !== {m_eck, m_eto}) begin
            n_fail++;
            $display("FAIL %s/a%0d errs: got ck=%b to=%b required ck=%b to=%b", tag, a,
                     err_cksum, err_timeout, m_eck, m_eto);
         end
         n_tests++;
         if (fail_cnt !== m_fail) begin
            n_fail++; $display("FAIL %s/a%0d fail_cnt: got %0d required %0d", tag, a, fail_cnt, m_fail);
         end

         if (last) begin
            wait_idle(PERIOD_CYC + 20, n);
            n_tests++;
            if (n != PERIOD_CYC) begin
               n_fail++; $display("FAIL %s/a%0d holdoff: got %0d required %0d", tag, a, n, PERIOD_CYC);
            end
            stop = 1'b1;
         end else begin
            wait_start(RETRY_CYC + 20, n);
            n_tests++;
            if (n != RETRY_CYC) begin
               n_fail++; $display("FAIL %s/a%0d retry_gap: got %0d required %0d", tag, a, n, RETRY_CYC);
            end
            if (n < 0) stop = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      model_clear();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({rd_start, valid, busy, err_cksum, err_timeout} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {rd_start, valid, busy, err_cksum, err_timeout});
      end
      n_tests++;
      if ({hum_int, hum_dec, temp_int, temp_dec, fail_cnt} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {hum_int, hum_dec, temp_int, temp_dec, fail_cnt});
      end
      rst = 1'b1;
      repeat (10) @(negedge clk);
      n_tests++;
      if ({rd_start, busy} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: got %b required 00", {rd_start, busy});
      end
   endtask

   task automatic test_good_read();
      plan_dly[0] = 7; plan_frame[0] = 40'h3C_00_19_05_5A;
      fire_trig("good");
      run_read("good");
      n_tests++;
      if ({hum_int, temp_int, temp_dec} !== 24'h3C_19_05) begin
         n_fail++; $display("FAIL good_bytes: got %h required 3c1905", {hum_int, temp_int, temp_dec});
      end
   endtask

   task automatic test_cksum_retry();
      plan_dly[0] = 4; plan_frame[0] = 40'h3C_00_19_05_00;
      plan_dly[1] = 6; plan_frame[1] = 40'h3C_00_19_05_5A;
      fire_trig("cksum_retry");
      run_read("cksum_retry");
   endtask

   task automatic test_double_timeout();
      plan_dly[0] = 0; plan_dly[1] = 0;
      fire_trig("dbl_timeout");
      run_read("dbl_timeout");
   endtask

   task automatic test_race_and_wrap();
      int n;
      plan_dly[0] = TIMEOUT_CYC; plan_frame[0] = 40'hFF_01_00_00_00;
      fire_trig("race_wrap");
      run_read("race_wrap");
      n_tests++;
      if ({hum_int, hum_dec} !== 16'hFF01) begin
         n_fail++; $display("FAIL wrap_bytes: got %h required ff01", {hum_int, hum_dec});
      end
      // One cycle too late: the read has already timed out and the strobe is ignored.
      fire_trig("late_done");
      repeat (TIMEOUT_CYC + 1) @(negedge clk);
      n_tests++;
      if (err_timeout !== 1'b1) begin
         n_fail++; $display("FAIL late_timeout: got %b required 1", err_timeout);
      end
      rd_done = 1'b1; rd_data = 40'h11_11_11_11_44;
      @(negedge clk);
      rd_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b0 || hum_int !== 8'hFF) begin
         n_fail++; $display("FAIL late_ignored: valid=%b hum_int=%h required 0/ff", valid, hum_int);
      end
      wait_start(RETRY_CYC + 20, n);
      n_tests++;
      if (n != RETRY_CYC - 2) begin
         n_fail++; $display("FAIL late_retry_gap: got %0d required %0d", n, RETRY_CYC - 2);
      end
      m_eto = 1'b1; m_eck = 1'b0;
      plan_dly[0] = 5; plan_frame[0] = 40'h11_11_11_11_44;
      run_read("late_retry");
   endtask

   task automatic test_random_reads();
      for (int k = 0; k < 12; k++) begin
         for (int a = 0; a < MAX_RETRY; a++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            plan_dly[a]   = (kind == 0) ? 0 : int'($urandom_range(1, TIMEOUT_CYC));
            plan_frame[a] = make_frame(kind == 1);
         end
         fire_trig("random");
         run_read("random");
      end
   endtask

   task automatic test_continuous();
      int n, s0, r;
      enable = 1'b1;
      wait_start(5, n);
      n_tests++;
      if (n != 1) begin
         n_fail++; $display("FAIL poll_first: got %0d required 1", n);
      end
      for (int k = 0; k < 4; k++) begin
         s0 = cyc;
         r  = int'($urandom_range(1, TIMEOUT_CYC));
         plan_dly[0] = r; plan_frame[0] = make_frame(1'b1);
         // Trig lands inside HOLDOFF for any reply delay and must be dropped.
         fork
            begin repeat (35) @(negedge clk); trig = 1'b1; @(negedge clk); trig = 1'b0; end
         join_none
         if (k == 3) fork
            begin repeat (3) @(negedge clk); enable = 1'b0; end
         join_none
         run_read("poll");
         if (k < 3) begin
            wait_start(5, n);
            n_tests++;
            if (cyc - s0 != r + 53) begin
               n_fail++; $display("FAIL poll_spacing: got %0d required %0d", cyc - s0, r + 53);
            end
         end
      end
      wait_start(100, n);
      n_tests++;
      if (n != -1) begin
         n_fail++; $display("FAIL poll_stop: rd_start after %0d cycles required none", n);
      end
   endtask

   task automatic test_reset_mid_read();
      int n;
      fire_trig("rst_mid");
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({hum_int, hum_dec, temp_int, temp_dec, fail_cnt, rd_start, valid, busy,
           err_cksum, err_timeout} !== 45'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h/%b required all 0",
                  {hum_int, hum_dec, temp_int, temp_dec, fail_cnt},
                  {rd_start, valid, busy, err_cksum, err_timeout});
      end
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      repeat (10) @(negedge clk);
      rd_done = 1'b1; rd_data = 40'h11_11_11_11_44;
      @(negedge clk);
      rd_done = 1'b0;
      wait_start(90, n);
      n_tests++;
      if (n != -1 || busy !== 1'b0 || hum_int !== 8'h00) begin
         n_fail++; $display("FAIL rst_mid_quiet: start=%0d busy=%b hum_int=%h required -1/0/00", n, busy, hum_int);
      end
      plan_dly[0] = 9; plan_frame[0] = make_frame(1'b1);
      fire_trig("rst_recover");
      run_read("rst_recover");
   endtask

   task automatic test_fail_saturation();
      for (int k = 0; k < 256; k++) begin
         plan_dly[0] = 0; plan_dly[1] = 0;
         fire_trig("saturate");
         run_read("saturate");
      end
      n_tests++;
      if (fail_cnt !== 8'hFF) begin
         n_fail++; $display("FAIL fail_cnt_sat: got %0d required 255", fail_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_read();
      test_cksum_retry();
      test_double_timeout();
      test_race_and_wrap();
      test_random_reads();
      test_continuous();
      test_reset_mid_read();
      test_fail_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dht_poll_scheduler.md
# dht_poll_scheduler

Sequencing controller for the DHT humidity/temperature reader. It issues read requests to the reader on a fixed poll period or on demand, and enforces the sensor's minimum inter-read interval. It supervises each transaction with a timeout, validates the 40-bit frame checksum, and retries on failure. It presents the last good humidity/temperature bytes to the rest of the design with a one-cycle valid strobe and error status.

## Interface
Parameters:
- MS_DIV, 100_000: clk cycles per millisecond tick
- PERIOD_MS, 2000: hold-off after every completed read (good or final fail), in ms
- RETRY_MS, 1000: hold-off before a retry, in ms
- TIMEOUT_MS, 10: max time from rd_start to rd_done, in ms
- MAX_RETRY, 3: total attempts per read (1 = no retry)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- enable  input  1  level; 1 = continuous polling
- trig  input  1  one-cycle on-demand read request
- rd_start  output  1  one-cycle start pulse to the reader
- rd_done  input  1  one-cycle strobe from the reader; rd_data is valid this cycle
- rd_data  input  40  raw frame, MSB first: hum_int, hum_dec, temp_int, temp_dec, cksum
- hum_int, hum_dec, temp_int, temp_dec  output  8 each  last good frame bytes
- valid  output  1  one-cycle strobe when the output bytes update
- err_cksum  output  1  last attempt failed on checksum
- err_timeout  output  1  last attempt timed out
- busy  output  1  state is not IDLE
- fail_cnt  output  8  saturating count of reads that failed after all retries

## Operation
- States: IDLE, ISSUE, WAIT_DONE, CHECK, HOLDOFF.
- IDLE: go to ISSUE if enable=1 or trig=1.
- ISSUE: rd_start=1 for exactly one cycle. Clear the timer. Go to WAIT_DONE.
- WAIT_DONE:
  - rd_done=1: latch rd_data and go to CHECK.
  - Timer reaches TIMEOUT_MS: set err_timeout, then take the failure path.
  - rd_done and timeout in the same cycle: rd_done wins.
- CHECK: compute sum = (b4+b3+b2+b1) mod 256 (8-bit wrap) and compare with b0.
  - Match: load the four output bytes, pulse valid, clear both err flags, set attempt=0, load hold=PERIOD_MS, go to HOLDOFF.
  - Mismatch: set err_cksum, clear err_timeout, then take the failure path.
- Failure path:
  - If attempt < MAX_RETRY-1: attempt++, set retry_pend, load hold=RETRY_MS.
  - Otherwise: fail_cnt++ (saturates at 255), attempt=0, load hold=PERIOD_MS.
  - Both cases go to HOLDOFF.
  - err_timeout is cleared whenever err_cksum is set, and vice versa.
- HOLDOFF: when the timer reaches hold:
  - If retry_pend: clear it and go to ISSUE, ignoring enable.
  - Otherwise go to IDLE.
- trig outside IDLE is ignored, not queued.
- rd_done outside WAIT_DONE is ignored.
- enable falling mid-transaction: the current read, its retries and the hold-off all complete, then the block stays in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0; attempt, retry_pend and timer 0.
- Timer: on every ISSUE→WAIT_DONE and every →HOLDOFF entry, both the prescaler and the ms counter restart.
- A wait of N ms expires exactly N·MS_DIV clk cycles after state entry.
- rd_start asserts in the cycle after the IDLE decision; IDLE→ISSUE takes 1 cycle.
- rd_done→valid latency: 2 cycles (WAIT_DONE→CHECK, then valid is registered out of CHECK). The output bytes change in the same cycle valid is high.
- Output bytes hold their value through failed reads.
- With enable held high, consecutive rd_start pulses are at least PERIOD_MS·MS_DIV cycles apart after a completed read, or RETRY_MS·MS_DIV cycles apart after a failed attempt.
- Reset asserted mid-operation returns the block to IDLE on the next edge. Latched data and errors are lost.

## Structure
- Package dht_pkg holds:
  - state enum
  - byte field offsets (HUM_INT_MSB=39 … CKSUM_LSB=0)
  - checksum function (four-byte 8-bit sum)
- Sub-module dht_ms_timer holds the prescaler (MS_DIV), the ms counter, the clear input and the `reached(N)` compare output.
- Total implementation: 150–250 lines.

## Test plan
All scenarios use MS_DIV=10, PERIOD_MS=5, RETRY_MS=2, TIMEOUT_MS=3, MAX_RETRY=2.
- **Good read:** trig; reply rd_done 7 cycles after rd_start with rd_data=0x3C00_1905_5A. Expect valid 2 cycles later; hum_int=0x3C, temp_int=0x19, temp_dec=0x05; errors 0; IDLE 50 cycles later.
- **Checksum fail, retry passes:** first reply 0x3C00_1905_00, then err_cksum=1. Expect a second rd_start 20 cycles after CHECK. Second reply 0x3C00_1905_5A, then valid=1, err_cksum=0, fail_cnt=0.
- **Double timeout:** no rd_done at all. Expect rd_start twice, err_timeout=1 and fail_cnt=1; outputs keep their previous values; 50-cycle hold-off.
- **Continuous polling:** enable=1, sensor always answers. Expect rd_start spacing = 50 + response + 3 cycles; a trig injected during HOLDOFF causes no extra rd_start.
- **Race and wrap:** rd_done in the exact timeout cycle is accepted. Frame 0xFF01_0000_00 passes the checksum (sum wraps to 0x00).
- **Reset mid-read:** rst low during WAIT_DONE. Expect all outputs 0 and busy=0 immediately; after release, no rd_start until trig or enable.
